// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle RV32I control FSM
// Sequences fetch/decode/execute/memory/writeback and drives ALU code, selects and datapath strobes.
module control_multiciclo #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        ZERO,
  input  logic        MEM_ACK,
  output logic [3:0]  ALU_CONTROL,
  output logic [1:0]  ALU_SRC_A,
  output logic [1:0]  ALU_SRC_B,
  output logic        ADDR_SEL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        IR_WRITE,
  output logic        PC_WRITE,
  output logic        REG_WRITE,
  output logic [1:0]  WB_SEL,
  output logic        ILLEGAL
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;
  localparam logic [3:0] ALU_SRA   = 4'b1110;
  localparam logic [3:0] ALU_EQ    = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR_TARGET, S_ILLEGAL
  } state_t;

  state_t state, state_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic       legal;
  logic [3:0] arith_op;
  logic [3:0] branch_op;
  logic       branch_taken;
  logic       unused_instr;

  assign opcode       = INSTR[6:0];
  assign funct3       = INSTR[14:12];
  assign bit30        = INSTR[30];
  assign unused_instr = ^{INSTR[31], INSTR[29:15], INSTR[11:7]};

  // Branch funct3 010/011 has no encoding, so it is rejected together with unknown opcodes.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_BRANCH: legal = (funct3[2:1] != 2'b01);
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000: arith_op = (opcode == OP_R && bit30) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      3'b111: arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  // funct3[0] marks the inverted condition (BNE, BGE, BGEU).
  always_comb begin
    case (funct3[2:1])
      2'b10:   branch_op = ALU_SLT;
      2'b11:   branch_op = ALU_SLTU;
      default: branch_op = ALU_EQ;
    endcase
    branch_taken = ZERO ^ funct3[0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ALU_CONTROL = ALU_ADD;
    ALU_SRC_A   = 2'd0;
    ALU_SRC_B   = 2'd0;
    ADDR_SEL    = 1'b0;
    MEM_REQ     = 1'b0;
    MEM_WE      = 1'b0;
    IR_WRITE    = 1'b0;
    PC_WRITE    = 1'b0;
    REG_WRITE   = 1'b0;
    WB_SEL      = 2'd0;
    ILLEGAL     = 1'b0;
    if (!RESET) begin
      case (state)
        S_FETCH: begin
          MEM_REQ   = 1'b1;
          ALU_SRC_A = 2'd1;
          ALU_SRC_B = 2'd2;
          if (MEM_ACK) begin
            IR_WRITE   = 1'b1;
            PC_WRITE   = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: state_next = legal ? S_EXEC : S_ILLEGAL;
        S_EXEC: begin
          state_next = S_FETCH;
          case (opcode)
            OP_R: begin
              ALU_CONTROL = arith_op;
              state_next  = S_WB;
            end
            OP_I: begin
              ALU_CONTROL = arith_op;
              ALU_SRC_B   = 2'd1;
              state_next  = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              ALU_SRC_B  = 2'd1;
              state_next = S_MEM;
            end
            OP_LUI: begin
              ALU_CONTROL = ALU_PASSB;
              ALU_SRC_B   = 2'd1;
              state_next  = S_WB;
            end
            OP_AUIPC: begin
              ALU_SRC_A  = 2'd2;
              ALU_SRC_B  = 2'd1;
              state_next = S_WB;
            end
            OP_BRANCH: begin
              ALU_CONTROL = branch_op;
              state_next  = branch_taken ? S_BR_TARGET : S_FETCH;
            end
            OP_JAL, OP_JALR: begin
              ALU_SRC_A = (opcode == OP_JAL) ? 2'd2 : 2'd0;
              ALU_SRC_B = 2'd1;
              PC_WRITE  = 1'b1;
              REG_WRITE = 1'b1;
              WB_SEL    = 2'd2;
            end
            default: state_next = S_FETCH;
          endcase
        end
        S_BR_TARGET: begin
          ALU_SRC_A  = 2'd2;
          ALU_SRC_B  = 2'd1;
          PC_WRITE   = 1'b1;
          state_next = S_FETCH;
        end
        S_MEM: begin
          MEM_REQ  = 1'b1;
          ADDR_SEL = 1'b1;
          MEM_WE   = (opcode == OP_STORE);
          if (MEM_ACK) state_next = (opcode == OP_STORE) ? S_FETCH : S_WB;
        end
        S_WB: begin
          REG_WRITE  = 1'b1;
          WB_SEL     = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
          state_next = S_FETCH;
        end
        S_ILLEGAL: begin
          if (ILLEGAL_TRAP) ILLEGAL    = 1'b1;
          else              state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - scoreboard bench for control_multiciclo
// Driver pushes per-cycle expected outputs from an instruction-class model; monitor pops and compares.
module tb_control_multiciclo;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTR = 32'h0;
  logic        ZERO = 1'b0;
  logic        MEM_ACK = 1'b0;
  logic [3:0]  ALU_CONTROL;
  logic [1:0]  ALU_SRC_A, ALU_SRC_B, WB_SEL;
  logic        ADDR_SEL, MEM_REQ, MEM_WE, IR_WRITE, PC_WRITE, REG_WRITE, ILLEGAL;

  control_multiciclo #(.ILLEGAL_TRAP(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .ZERO(ZERO), .MEM_ACK(MEM_ACK),
    .ALU_CONTROL(ALU_CONTROL), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
    .ADDR_SEL(ADDR_SEL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .IR_WRITE(IR_WRITE),
    .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE), .WB_SEL(WB_SEL), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write;
    logic [1:0] wb_sel;
    logic [3:0] alu;
    logic [1:0] src_a, src_b;
    logic       illegal, care_alu, care_a, care_all;
  } exp_t;

  typedef enum {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD} cls_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] cur_instr = 32'h0;
  logic        cur_zero = 1'b0;
  logic [6:0]  ops[9];

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e = '0;
    e.care_all = 1'b1;
    return e;
  endfunction

  function automatic exp_t alu_exp(input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    e = '0;
    e.alu = alu; e.src_a = a; e.src_b = b;
    e.care_alu = 1'b1; e.care_a = 1'b1;
    return e;
  endfunction

  function automatic cls_t classify(input logic [31:0] ins);
    for (int i = 0; i < 9; i++)
      if (ins[6:0] == ops[i]) begin
        if (i == 4 && ins[14:13] == 2'b01) return C_BAD;
        return cls_t'(i);
      end
    return C_BAD;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b30, input logic is_r);
    logic [3:0] tbl[8];
    tbl = '{4'b0000, 4'b1000, 4'b0100, 4'b1101, 4'b1001, 4'b1010, 4'b0001, 4'b0010};
    if (f3 == 3'd0 && is_r && b30) return 4'b0111;
    if (f3 == 3'd5 && b30) return 4'b1110;
    return tbl[f3];
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge CLK);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        ok = (MEM_REQ === e.mem_req) && (IR_WRITE === e.ir_write) && (PC_WRITE === e.pc_write)
             && (REG_WRITE === e.reg_write) && (ILLEGAL === e.illegal);
        if (e.mem_req || e.care_all) ok = ok && (ADDR_SEL === e.addr_sel) && (MEM_WE === e.mem_we);
        if (e.reg_write || e.care_all) ok = ok && (WB_SEL === e.wb_sel);
        if (e.care_alu || e.care_all) ok = ok && (ALU_CONTROL === e.alu) && (ALU_SRC_B === e.src_b);
        if (e.care_a || e.care_all) ok = ok && (ALU_SRC_A === e.src_a);
        tests++;
        if (!ok) begin
          fails++;
          $display("FAIL outputs cyc=%0d instr=%h got req=%b we=%b as=%b ir=%b pc=%b rw=%b wb=%0d alu=%b a=%0d b=%0d ill=%b exp req=%b we=%b as=%b ir=%b pc=%b rw=%b wb=%0d alu=%b a=%0d b=%0d ill=%b",
                   cyc, INSTR, MEM_REQ, MEM_WE, ADDR_SEL, IR_WRITE, PC_WRITE, REG_WRITE, WB_SEL,
                   ALU_CONTROL, ALU_SRC_A, ALU_SRC_B, ILLEGAL, e.mem_req, e.mem_we, e.addr_sel,
                   e.ir_write, e.pc_write, e.reg_write, e.wb_sel, e.alu, e.src_a, e.src_b, e.illegal);
        end
        tests++;
        if (PC_WRITE === 1'b1 && MEM_WE === 1'b1) begin
          fails++;
          $display("FAIL pc_we_exclusive cyc=%0d got pc_write=1 mem_we=1 exp not both", cyc);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic ack, input exp_t e);
    @(posedge CLK);
    #1;
    RESET = rst; MEM_ACK = ack; INSTR = cur_instr; ZERO = cur_zero;
    q.push_back(e);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z,
                           input logic abort, input int hold);
    exp_t e;
    cls_t c;
    logic [2:0] f3;
    c = classify(ins);
    f3 = ins[14:12];
    cur_instr = ins;
    cur_zero = z;
    e = alu_exp(4'b0000, 2'd1, 2'd2);
    e.mem_req = 1'b1;
    for (int i = 0; i < fw; i++) step(1'b0, 1'b0, e);
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(1'b0, 1'b1, e);
    step(1'b0, 1'b0, blank());
    case (c)
      C_R, C_I, C_LUI, C_AUIPC: begin
        if (c == C_LUI) begin
          e = alu_exp(4'b1100, 2'd0, 2'd1);
          e.care_a = 1'b0;
        end else if (c == C_AUIPC) e = alu_exp(4'b0000, 2'd2, 2'd1);
        else e = alu_exp(ref_alu(f3, ins[30], c == C_R), 2'd0, (c == C_R) ? 2'd0 : 2'd1);
        step(1'b0, 1'b0, e);
        e = blank(); e.reg_write = 1'b1;
        step(1'b0, 1'b0, e);
      end
      C_LOAD, C_STORE: begin
        step(1'b0, 1'b0, alu_exp(4'b0000, 2'd0, 2'd1));
        if (abort) begin
          step(1'b1, 1'b0, rst_exp());
          return;
        end
        e = blank(); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (c == C_STORE);
        for (int i = 0; i < mw; i++) step(1'b0, 1'b0, e);
        step(1'b0, 1'b1, e);
        if (c == C_LOAD) begin
          e = blank(); e.reg_write = 1'b1; e.wb_sel = 2'd1;
          step(1'b0, 1'b0, e);
        end
      end
      C_BR: begin
        step(1'b0, 1'b0, alu_exp(f3[2] ? (f3[1] ? 4'b1101 : 4'b0100) : 4'b1111, 2'd0, 2'd0));
        if (f3[0] ? !z : z) begin
          e = alu_exp(4'b0000, 2'd2, 2'd1); e.pc_write = 1'b1;
          step(1'b0, 1'b0, e);
        end
      end
      C_JAL, C_JALR: begin
        e = alu_exp(4'b0000, (c == C_JAL) ? 2'd2 : 2'd0, 2'd1);
        e.pc_write = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'd2;
        step(1'b0, 1'b0, e);
      end
      default: begin
        e = blank(); e.illegal = 1'b1;
        for (int i = 0; i < hold; i++) step(1'b0, 1'b0, e);
        step(1'b1, 1'b0, rst_exp());
      end
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    int k;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rst_exp());
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, 0);
    run_instr(32'h4032D293, 1, 0, 1'b0, 1'b0, 0);
    run_instr(32'h40208133, 0, 0, 1'b0, 1'b0, 0);
    run_instr(32'h0000A183, 0, 2, 1'b0, 1'b0, 0);
    run_instr(32'h00209463, 0, 0, 1'b1, 1'b0, 0);
    run_instr(32'h00209463, 0, 0, 1'b0, 1'b0, 0);
    run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, 10);
    run_instr(32'h0020A023, 0, 1, 1'b0, 1'b1, 0);
    run_instr(32'h0020A023, 0, 1, 1'b0, 1'b0, 0);
    run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0, 0);
    run_instr(32'h000080E7, 2, 0, 1'b0, 1'b0, 0);
    run_instr(32'h123450B7, 0, 0, 1'b0, 1'b0, 0);
    run_instr(32'h00001097, 0, 0, 1'b0, 1'b0, 0);
    for (int n = 0; n < 200; n++) begin
      ins = $urandom();
      k = $urandom_range(0, 19);
      if (k < 18) begin
        ins[6:0] = ops[k % 9];
        if (k % 9 == 4 && ins[14:13] == 2'b01) ins[14] = 1'b1;
      end else if (k == 18) begin
        while (classify(ins) != C_BAD) ins[6:0] = 7'($urandom());
      end else begin
        ins[6:0] = ops[4];
        ins[14:13] = 2'b01;
      end
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom()),
                ($urandom_range(0, 9) == 0), $urandom_range(1, 5));
    end
    @(negedge CLK);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drained got %0d pending exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
